// File: rtl/eca_inbuf_pp.sv
// Ping-pong input buffer for the erasure coding engine: host fills one bank while the engine drains the other.
// Optional build macro ECA_INBUF_UNF_ERR_EN enables the sticky read-underflow flag inbuf_err[1].
module eca_inbuf_lane #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int WD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [WD_W-1:0]   wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [WD_W-1:0]   rd_word,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2][DEPTH];

  // Storage itself is never reset; only the output register is.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_bank][wr_word] <= wr_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_bank][rd_word];
endmodule

module eca_inbuf_pp #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WD_W   = $clog2(DEPTH),
  localparam int ADDR_W = CH_W + WD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inbuf_wr_req,
  input  logic [ADDR_W-1:0]        inbuf_wr_addr,
  input  logic [DATA_W-1:0]        inbuf_wr_data,
  input  logic                     inbuf_wr_last,
  output logic                     inbuf_wr_ready,
  input  logic                     eng_rd_req,
  output logic                     eng_rd_avail,
  output logic [NUM_CH*DATA_W-1:0] eng_rd_data,
  output logic                     eng_rd_val,
  output logic                     eng_rd_last,
  output logic [1:0]               inbuf_err,
  input  logic                     err_clr
);
  localparam int STAGES = 1;
  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(NUM_CH);

  typedef enum logic [1:0] {B_FREE, B_FULL, B_DRAIN} bank_st_e;
  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [WD_W-1:0] word;
  } wr_addr_t;

  bank_st_e                         bank_st [2];
  logic                             wr_bank, rd_bank;
  logic [WD_W-1:0]                  rd_cnt;
  wr_addr_t                         wa;
  logic                             ch_ok, wr_acc, commit, wr_drop;
  logic                             rd_acc, rd_done;
  logic [STAGES:0]                  vld_pipe;
  logic                             last_q;
  logic                             err_wr_q;
  logic [NUM_CH-1:0][DATA_W-1:0]    rd_lane;

  assign wa             = inbuf_wr_addr;
  assign ch_ok          = {1'b0, wa.ch} < CH_LIM;
  assign inbuf_wr_ready = (bank_st[wr_bank] == B_FREE);
  assign eng_rd_avail   = (bank_st[rd_bank] != B_FREE);
  assign wr_acc         = inbuf_wr_req & inbuf_wr_ready & ch_ok;
  assign wr_drop        = inbuf_wr_req & ~wr_acc;
  assign commit         = wr_acc & inbuf_wr_last;
  assign rd_acc         = eng_rd_req & eng_rd_avail;
  assign rd_done        = rd_acc & (rd_cnt == WD_W'(DEPTH-1));

  // A FULL bank always passes through DRAIN because the first read is never word DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) bank_st[b] <= B_FREE;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        case (bank_st[b])
          B_FREE:  if (commit  && (wr_bank == b[0])) bank_st[b] <= B_FULL;
          B_FULL:  if (rd_acc  && (rd_bank == b[0])) bank_st[b] <= B_DRAIN;
          B_DRAIN: if (rd_done && (rd_bank == b[0])) bank_st[b] <= B_FREE;
          default: bank_st[b] <= B_FREE;
        endcase
      end
      if (commit)  wr_bank <= ~wr_bank;
      if (rd_acc)  rd_cnt  <= rd_cnt + WD_W'(1);
      if (rd_done) rd_bank <= ~rd_bank;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    eca_inbuf_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WD_W(WD_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_acc && (wa.ch == CH_W'(c))),
      .wr_bank (wr_bank),
      .wr_word (wa.word),
      .wr_data (inbuf_wr_data),
      .rd_en   (rd_acc),
      .rd_bank (rd_bank),
      .rd_word (rd_cnt),
      .rd_data (rd_lane[c])
    );
  end

  assign eng_rd_data = rd_lane;

  assign vld_pipe[0] = rd_acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      last_q             <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      last_q             <= rd_done;
    end

  assign eng_rd_val  = vld_pipe[STAGES];
  assign eng_rd_last = last_q;

  // Sticky flags: a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_wr_q <= 1'b0;
    else        err_wr_q <= (err_wr_q & ~err_clr) | wr_drop;

`ifdef ECA_INBUF_UNF_ERR_EN
  logic err_unf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_unf_q <= 1'b0;
    else        err_unf_q <= (err_unf_q & ~err_clr) | (eng_rd_req & ~eng_rd_avail);
  assign inbuf_err = {err_unf_q, err_wr_q};
`else
  assign inbuf_err = {1'b0, err_wr_q};
`endif
endmodule

// File: tb/tb_eca_inbuf_pp.sv
// Scoreboarded bench for eca_inbuf_pp: bank-occupancy reference model, directed ping-pong/error/reset cases,
// randomized traffic, plus a NUM_CH=3 instance for the out-of-range channel case.
module tb_eca_inbuf_pp;
  localparam int DW = 32, NC = 4, DEP = 16, WD_W = 4, ADDR_W = 6;
`ifdef ECA_INBUF_UNF_ERR_EN
  localparam bit UNF = 1'b1;
`else
  localparam bit UNF = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              inbuf_wr_req = 0, inbuf_wr_last = 0, eng_rd_req = 0, err_clr = 0;
  logic [ADDR_W-1:0] inbuf_wr_addr = '0;
  logic [DW-1:0]     inbuf_wr_data = '0;
  logic              inbuf_wr_ready, eng_rd_avail, eng_rd_val, eng_rd_last;
  logic [NC*DW-1:0]  eng_rd_data;
  logic [1:0]        inbuf_err;

  eca_inbuf_pp #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .inbuf_wr_req(inbuf_wr_req), .inbuf_wr_addr(inbuf_wr_addr),
    .inbuf_wr_data(inbuf_wr_data), .inbuf_wr_last(inbuf_wr_last), .inbuf_wr_ready(inbuf_wr_ready),
    .eng_rd_req(eng_rd_req), .eng_rd_avail(eng_rd_avail), .eng_rd_data(eng_rd_data),
    .eng_rd_val(eng_rd_val), .eng_rd_last(eng_rd_last), .inbuf_err(inbuf_err), .err_clr(err_clr));

  // Three-channel instance: address still carries a 2-bit channel, so channel 3 is out of range.
  logic              w3_req = 0, w3_last = 0, r3_req = 0, c3_clr = 0;
  logic [ADDR_W-1:0] w3_addr = '0;
  logic [DW-1:0]     w3_data = '0;
  logic              w3_ready, r3_avail, r3_val, r3_last;
  logic [3*DW-1:0]   r3_data;
  logic [1:0]        e3;

  eca_inbuf_pp #(.DATA_W(DW), .NUM_CH(3), .DEPTH(DEP)) dut3 (
    .clk(clk), .rst_n(rst_n), .inbuf_wr_req(w3_req), .inbuf_wr_addr(w3_addr),
    .inbuf_wr_data(w3_data), .inbuf_wr_last(w3_last), .inbuf_wr_ready(w3_ready),
    .eng_rd_req(r3_req), .eng_rd_avail(r3_avail), .eng_rd_data(r3_data),
    .eng_rd_val(r3_val), .eng_rd_last(r3_last), .inbuf_err(e3), .err_clr(c3_clr));

  typedef struct packed { logic [NC*DW-1:0] d; logic l; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  // Reference model: committed-bank count, alternating fill/drain banks, word index of the drain.
  logic [DW-1:0] mem_m [2][NC][DEP];
  int occ = 0, wp = 0, rp = 0, rc = 0;
  logic [1:0] err_m = 2'b00;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (eng_rd_val) begin
      if (q.size() == 0) chk("unexpected_val", 1, 0);
      else begin
        e = q.pop_front();
        chk("rd_data", eng_rd_data, e.d);
        chk("rd_last", eng_rd_last, e.l);
      end
    end else if (eng_rd_last) chk("last_without_val", eng_rd_last, 0);
  end

  // Called just after a negedge: check state-level outputs, drive one cycle, advance the model.
  task automatic step(input bit wr, input int ch, input int wd, input logic [DW-1:0] d,
                      input bit lst, input bit rd, input bit clr);
    bit wacc, racc;
    exp_t e;
    chk("wr_ready", inbuf_wr_ready, occ < 2);
    chk("rd_avail", eng_rd_avail, occ > 0);
    chk("inbuf_err", inbuf_err, err_m);
    inbuf_wr_req  = wr;
    inbuf_wr_addr = ADDR_W'((ch << WD_W) | wd);
    inbuf_wr_data = d;
    inbuf_wr_last = lst;
    eng_rd_req    = rd;
    err_clr       = clr;
    wacc = wr && (occ < 2) && (ch < NC);
    racc = rd && (occ > 0);
    if (racc) begin
      for (int c = 0; c < NC; c++) e.d[c*DW +: DW] = mem_m[rp][c][rc];
      e.l = (rc == DEP-1);
      q.push_back(e);
    end
    if (clr) err_m = 2'b00;
    if (wr && !wacc) err_m[0] = 1'b1;
    if (rd && !racc && UNF) err_m[1] = 1'b1;
    if (wacc) begin
      mem_m[wp][ch][wd] = d;
      if (lst) begin occ++; wp ^= 1; end
    end
    if (racc) begin
      rc++;
      if (rc == DEP) begin rc = 0; rp ^= 1; occ--; end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic drain();
    repeat (DEP) step(0, 0, 0, '0, 0, 1, 0);
  endtask

  function automatic logic [DW-1:0] pat(input int tag, input int c, input int w);
    return DW'((tag << 16) | (c << 8) | w);
  endfunction

  task automatic fill(input int tag);
    for (int c = 0; c < NC; c++)
      for (int w = 0; w < DEP; w++)
        step(1, c, w, pat(tag, c, w), (c == NC-1) && (w == DEP-1), 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inbuf_wr_req = 0; inbuf_wr_last = 0; eng_rd_req = 0; err_clr = 0;
    q.delete();
    occ = 0; wp = 0; rp = 0; rc = 0; err_m = 2'b00;
    #1;
    chk("rst_wr_ready", inbuf_wr_ready, 1);
    chk("rst_rd_avail", eng_rd_avail, 0);
    chk("rst_rd_data", eng_rd_data, 0);
    chk("rst_rd_val", eng_rd_val, 0);
    chk("rst_rd_last", eng_rd_last, 0);
    chk("rst_err", inbuf_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Single bank fill then back-to-back drain.
    fill(0);
    drain();
    idle(2);

    // Ping-pong: commit of the second bank lands on the same edge the first finishes draining.
    fill(1);
    for (int i = 0; i < NC*DEP; i++)
      step(1, i / DEP, i % DEP, pat(2, i / DEP, i % DEP), i == NC*DEP-1, i >= NC*DEP-DEP, 0);
    drain();
    idle(2);

    // Both banks full: extra write is dropped, then cleared, then both drain intact.
    fill(3);
    fill(4);
    step(1, 1, 2, 32'hdead_beef, 1, 0, 0);
    idle(1);
    step(0, 0, 0, '0, 0, 0, 1);
    drain();
    drain();
    idle(2);

    // Underflow reads, then clear together with a fresh underflow (set wins), then plain clear.
    repeat (3) step(0, 0, 0, '0, 0, 1, 0);
    step(0, 0, 0, '0, 0, 1, 1);
    step(0, 0, 0, '0, 0, 0, 1);
    idle(1);

    // Reset mid-drain with word 7 next.
    fill(5);
    repeat (7) step(0, 0, 0, '0, 0, 1, 0);
    idle(1);
    do_reset();
    fill(6);
    drain();
    idle(2);

    // Randomized traffic with partial fills, stale words and out-of-order addressing.
    repeat (4000) begin
      int ch, wd;
      bit wr, lst, rd, clr;
      ch  = $urandom_range(0, NC-1);
      wd  = $urandom_range(0, DEP-1);
      wr  = ($urandom_range(0, 9) < 6);
      lst = ($urandom_range(0, 15) == 0);
      rd  = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 49) == 0);
      step(wr, ch, wd, $urandom, lst, rd, clr);
    end
    idle(3);
    chk("scoreboard_empty", q.size(), 0);

    // Three-channel build: write to channel 3 carrying last must be dropped and must not commit.
    w3_req = 1; w3_addr = ADDR_W'((3 << WD_W) | 0); w3_data = 32'hbad0_0bad; w3_last = 1;
    @(negedge clk);
    w3_req = 0; w3_last = 0;
    chk("nc3_err_drop", e3, {1'b0, 1'b1});
    chk("nc3_ready", w3_ready, 1);
    @(negedge clk);
    chk("nc3_no_commit", r3_avail, 0);
    c3_clr = 1;
    for (int c = 0; c < 3; c++)
      for (int w = 0; w < DEP; w++) begin
        w3_req = 1; w3_addr = ADDR_W'((c << WD_W) | w); w3_data = pat(9, c, w);
        w3_last = (c == 2) && (w == DEP-1);
        @(negedge clk);
        c3_clr = 0;
      end
    w3_req = 0; w3_last = 0;
    chk("nc3_err_cleared", e3, 0);
    chk("nc3_avail", r3_avail, 1);
    for (int w = 0; w < DEP; w++) begin
      r3_req = 1;
      @(negedge clk);
      r3_req = 0;
      chk("nc3_val", r3_val, 1);
      chk("nc3_last", r3_last, w == DEP-1);
      for (int c = 0; c < 3; c++) chk("nc3_data", r3_data[c*DW +: DW], pat(9, c, w));
    end
    @(negedge clk);
    chk("nc3_free", w3_ready, 1);
    chk("nc3_drained", r3_avail, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
